ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single 32-bit read/write port of the instruction/data RAM between two requesters.
- Master 0 is the instruction-line refill. It is read-only and issues critical-word-first wrapping bursts of BURST_LEN words.
- Master 1 is the data side (LSU). It issues single-word reads and writes with byte enables.
- The block sits between the core memory interfaces and the RAM. It owns arbitration, burst address sequencing and routing of read data back to the requester.

Parameters:
- ADDR_WIDTH, 20, byte address width on all ports.
- BURST_LEN, 4, words per master-0 burst. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  line refill request; held until m0_gnt_o.
- m0_addr_i  in  ADDR_WIDTH  critical byte address; bits [1:0] ignored.
- m0_gnt_o  out  1  request accepted; first beat issued this cycle.
- m0_rvalid_o  out  1  burst beat data valid.
- m0_rdata_o  out  32  beat data.
- m0_last_o  out  1  marks the final beat's rvalid.
- m1_req_i  in  1  data request; held stable until m1_gnt_o.
- m1_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- m1_we_i  in  1  1 = write, 0 = read.
- m1_be_i  in  4  byte enables for writes.
- m1_wdata_i  in  32  write data.
- m1_gnt_o  out  1  request accepted and issued this cycle.
- m1_rvalid_o  out  1  response; read data, or write acknowledge.
- m1_rdata_o  out  32  read data; don't-care for writes.
- ram_en_o  out  1  RAM port enable.
- ram_addr_o  out  ADDR_WIDTH  word-aligned byte address; [1:0] = 0.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid one cycle after an enabled read.

Behaviour:
- RAM timing: read data appears on ram_rdata_i in the cycle after ram_en_o=1 with ram_we_o=0. One access per cycle.
- State machine:
  - States are IDLE and BURST.
  - Registers: beat counter (log2 BURST_LEN bits), line base, start offset, prio bit, rsp_owner (none/m0/m1), rsp_last.
- IDLE, arbitration (combinational, same cycle as request):
  - Only m0 requests: grant m0.
  - Only m1 requests: grant m1.
  - Both request: grant m0 if prio=0, else m1.
  - gnt and ram_en_o are asserted in the same cycle.
- m0 grant:
  - line_base = m0_addr_i with the low log2(BURST_LEN)+2 bits cleared.
  - off = word index of m0_addr_i within the line.
  - Beat i address = line_base + ((off+i) mod BURST_LEN)*4, i.e. wrap-around within the line.
  - Beat 0 is issued in the grant cycle. Go to BURST.
  - In BURST, beats 1..BURST_LEN-1 are issued back-to-back, one per cycle, with ram_we_o=0.
  - After the last beat, return to IDLE and set prio=1.
  - m0_gnt_o pulses only in the beat-0 cycle.
  - m1_gnt_o is held at 0 throughout BURST.
- m1 grant:
  - Single access; ram_we/be/wdata/addr are driven from m1.
  - Set prio=0. Stay in IDLE.
- No bubbles:
  - Arbitration resumes in the cycle immediately after the last burst beat.
  - Back-to-back m1 grants are allowed when m0 is idle.
- Responses:
  - Every granted access produces exactly one rvalid to its owner, exactly 1 cycle later.
  - m0_rdata_o and m1_rdata_o = ram_rdata_i.
  - m0_last_o=1 coincident with the rvalid of beat BURST_LEN-1.
  - m1 writes also return m1_rvalid_o (acknowledge).
- Idle RAM port: when nothing is granted, ram_en_o=0 and ram_we_o=0; address/data are don't-care.
- Reset values (while rst_i=1 and after release):
  - state=IDLE, counter=0, prio=0, rsp_owner=none.
  - All gnt, rvalid, last, ram_en_o and ram_we_o = 0.
  - Data outputs = 0.
  - Grants and ram_en_o are gated low while rst_i=1.
- Reset mid-burst: the burst is abandoned, in-flight responses are dropped, and nothing further is issued. m0 must re-request after release.
- Protocol violation: dropping a request before its grant is illegal. The verification bench asserts req stability.

Test Plan:
- Reset release, m0_req with addr 0x00100 (no m1): gnt in cycle 0. ram_addr 0x100,0x104,0x108,0x10C on consecutive cycles. rvalid cycles 1-4, last in cycle 4 only.
- m0 addr 0x0010C: beat addresses wrap as 0x10C,0x100,0x104,0x108. m0_rdata matches preloaded words in the same order.
- m0 and m1 request together after reset: m0 wins (prio=0). m1 is granted the cycle after the last m0 beat. Both requesting again next time: m1 wins.
- m1 write be=4'b0101, wdata 0xAABBCCDD to 0x00200, then read 0x00200: ram signals match. Write ack rvalid arrives 1 cycle later. Read returns 0x00BB00DD over a zeroed word.
- m1 request during beat 1 of a burst: m1_gnt_o stays 0 through beat 3, then asserts the next cycle. No ram_en gap between the two accesses.
- rst_i asserted during beat 2: outputs are 0 immediately. No further rvalid or last. After release, a new m0 request restarts at beat 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one 32-bit RAM port between a read-only wrapping burst refill (m0)
// and a single-word read/write data port (m1). One access is issued per cycle.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    output logic                  m0_last_o,

    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int OFF_W  = $clog2(BURST_LEN);
    localparam int LINE_W = OFF_W + 2;
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    state_t                       state_reg, state_next;
    logic [OFF_W-1:0]             cnt_reg, cnt_next;
    logic [ADDR_WIDTH-LINE_W-1:0] line_reg, line_next;
    logic [OFF_W-1:0]             off_reg, off_next;
    logic                         prio_reg, prio_next;
    owner_t                       owner_reg, owner_next;
    logic                         last_reg, last_next;

    logic                         gnt0;
    logic                         gnt1;
    logic                         burst_beat;
    logic                         final_beat;
    logic [OFF_W-1:0]             beat_word;

    // Low address bits are byte offsets the word-wide RAM never sees.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

    // Arbitration is combinational so a grant and its RAM access share a cycle.
    always_comb begin
        gnt0       = !rst_i && (state_reg == IDLE) && m0_req_i && (!m1_req_i || !prio_reg);
        gnt1       = !rst_i && (state_reg == IDLE) && m1_req_i && !gnt0;
        burst_beat = !rst_i && (state_reg == BURST);
        final_beat = burst_beat && (cnt_reg == CNT_LAST);
        beat_word  = off_reg + cnt_reg;
    end

    // State register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt0)       state_next = BURST;
            BURST:   if (final_beat) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Burst sequencing, fairness and response tracking
    always_comb begin
        cnt_next   = cnt_reg;
        line_next  = line_reg;
        off_next   = off_reg;
        prio_next  = prio_reg;
        owner_next = OWN_NONE;
        last_next  = final_beat;
        if (gnt0) begin
            cnt_next   = CNT_ONE;
            line_next  = m0_addr_i[ADDR_WIDTH-1:LINE_W];
            off_next   = m0_addr_i[LINE_W-1:2];
            owner_next = OWN_M0;
        end else if (burst_beat) begin
            cnt_next   = cnt_reg + CNT_ONE;
            owner_next = OWN_M0;
            if (final_beat) begin
                prio_next = 1'b1;
            end
        end else if (gnt1) begin
            prio_next  = 1'b0;
            owner_next = OWN_M1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg   <= '0;
            line_reg  <= '0;
            off_reg   <= '0;
            prio_reg  <= 1'b0;
            owner_reg <= OWN_NONE;
            last_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            line_reg  <= line_next;
            off_reg   <= off_next;
            prio_reg  <= prio_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    // Output logic
    always_comb begin
        m0_gnt_o   = gnt0;
        m1_gnt_o   = gnt1;
        ram_en_o   = gnt0 || gnt1 || burst_beat;
        ram_we_o   = gnt1 && m1_we_i;
        ram_addr_o = '0;
        if (gnt0) begin
            ram_addr_o = {m0_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (burst_beat) begin
            ram_addr_o = {line_reg, beat_word, 2'b00};
        end else if (gnt1) begin
            ram_addr_o = {m1_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end

        m0_rvalid_o = (owner_reg == OWN_M0);
        m0_last_o   = (owner_reg == OWN_M0) && last_reg;
        m0_rdata_o  = (owner_reg == OWN_M0) ? ram_rdata_i : 32'h0;
        m1_rvalid_o = (owner_reg == OWN_M1);
        m1_rdata_o  = (owner_reg == OWN_M1) ? ram_rdata_i : 32'h0;
    end

    // Write lanes carry m1 data only while m1 owns the port; zero otherwise.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_be_o[gi]            = gnt1 && m1_be_i[gi];
            assign ram_wdata_o[8*gi +: 8]  = gnt1 ? m1_wdata_i[8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule
